mult16_seq: RTL and testbench



---
 rtl/mult16_seq.sv | 115 +++++++++++
 tb/tb_mult16_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mult16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier: one partial-product add per clock
// through a single add16bits ripple adder, 16 iterations, start/done handshake.

module add16bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        carry_out
);

  logic [16:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = carry_in;
    for (int i = 0; i < 16; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    carry_out = carry[16];
  end

endmodule

module mult16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [32:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;

  logic [15:0] add_sum;
  logic        add_co;
  logic [16:0] high;
  logic [32:0] acc_next;

  add16bits u_add (
    .a         (acc_q[31:16]),
    .b         (mcand_q),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_co)
  );

  // Conditional add of the multiplicand, then a 33-bit right shift.
  always_comb begin
    high     = acc_q[0] ? {add_co, add_sum} : {1'b0, acc_q[31:16]};
    acc_next = {1'b0, high, acc_q[15:1]};
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {17'b0, b};
          cnt_d   = 4'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_next;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          product_d = acc_next[31:0];
          state_d   = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_mult16_seq.sv
// Self-checking bench for mult16_seq: latency-countdown reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized regression.

module tb_mult16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mult16_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: an accepted start yields a*b, visible 16 edges later, busy for 17 cycles.
  int          m_left;
  logic [31:0] m_pend;
  logic [31:0] m_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_pend = '0;
      m_prod = '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_pend = 32'(a) * 32'(b);
        m_left = 17;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) m_prod = m_pend;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_model", 32'(busy), 32'(m_left != 0));
      check("done_model", 32'(done), 32'(m_left == 1));
      check("product_model", product, m_prod);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply, optionally disturbing start/a/b during RUN; checks done latency.
  task automatic mul(input logic [15:0] x, input logic [15:0] y, input bit scramble,
                     output logic [31:0] res);
    int edges;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    for (int k = 1; k <= 40; k++) begin
      if (scramble) begin
        a     = 16'($urandom);
        b     = 16'($urandom);
        start = (k < 15);
      end
      tick();
      if (done) begin
        edges = k;
        break;
      end
    end
    start = 1'b0;
    check("done_latency", 32'(edges), 32'd16);
    res = product;
    tick();
    check("done_falls", 32'(done), 32'd0);
    check("busy_falls", 32'(busy), 32'd0);
  endtask

  logic [31:0] r;
  logic [15:0] x, y;
  int          n_done;
  int          t1;
  int          gap;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    mul(16'd3, 16'd5, 1'b0, r);
    check("mul_3x5", r, 32'h0000_000F);
    mul(16'hFFFF, 16'hFFFF, 1'b0, r);
    check("mul_ffff_ffff", r, 32'hFFFE_0001);
    mul(16'h1234, 16'h0000, 1'b0, r);
    check("mul_x_zero", r, 32'h0000_0000);

    // Operand changes and start pulses during RUN must not affect the result.
    mul(16'h00AB, 16'h0100, 1'b1, r);
    check("mul_latched", r, 32'h0000_AB00);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) n_done++;
    end
    check("no_second_done", 32'(n_done), 32'd0);

    // Asynchronous reset mid-RUN.
    a     = 16'hFFFF;
    b     = 16'h0002;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mul(16'd2, 16'd2, 1'b0, r);
    check("mul_after_rst", r, 32'd4);

    // start held high: back-to-back issue every 18 cycles.
    a     = 16'h8000;
    b     = 16'h0002;
    start = 1'b1;
    tick();
    a  = 16'h00FF;
    b  = 16'h0101;
    t1 = -1;
    gap = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done) begin
        if (t1 < 0) begin
          t1 = cyc;
          check("hold_prod1", product, 32'h0001_0000);
        end else begin
          gap = cyc - t1;
          check("hold_prod2", product, 32'h0000_FFFF);
          break;
        end
      end
    end
    start = 1'b0;
    check("hold_gap", 32'(gap), 32'd18);
    for (int k = 0; k < 20; k++) tick();

    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      mul(x, y, 1'b0, r);
      check("rand_product", r, 32'(x) * 32'(y));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
